// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives the 2-bit select of the 4:1 mux, waits a settle
// interval per channel, captures the mux output and hands each sample to a
// downstream consumer over valid/ready. Enabled channels are scanned in
// ascending order.
//
// Optional build macro: MUX_SEL_SEQUENCER_CONTINUOUS_EN
//   defined   -> after the last enabled channel is accepted the sweep wraps to
//                the lowest latched channel and repeats until stop/reset.
//   undefined -> one sweep per start, then back to IDLE.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero mask
// SETTLE | select held, dwell counter running down to capture
// HOLD   | sample presented, waiting for the consumer handshake
module mux_sel_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               stop_in,
    input  logic [NUM_CH-1:0]  ch_mask_in,
    input  logic [DWELL_W-1:0] dwell_in,
    input  logic               mux_y_in,
    output logic [SEL_W-1:0]   sel_out,
    output logic               sample_valid_out,
    output logic               sample_data_out,
    output logic [SEL_W-1:0]   sample_ch_out,
    input  logic               sample_ready_in,
    output logic               busy_out,
    output logic               scan_done_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic               r_valid;
    logic               r_data;
    logic [SEL_W-1:0]   r_ch;
    logic               r_busy;
    logic               r_done;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic [SEL_W-1:0]   w_first_in_ch;
    logic               w_next_found;
    logic [SEL_W-1:0]   w_next_ch;
    logic               w_handshake;

    // A dwell of zero still needs one settle cycle before capture.
    assign w_dwell_eff = (dwell_in == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_in;
    assign w_handshake = r_valid & sample_ready_in;

    // Lowest enabled channel of the incoming mask (start of a sweep).
    always_comb begin
        w_first_in_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_in[i]) w_first_in_ch = i[SEL_W-1:0];
        end
    end

    // Next enabled channel strictly above the current select, latched mask.
    always_comb begin
        w_next_found = 1'b0;
        w_next_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_found = 1'b1;
                w_next_ch    = i[SEL_W-1:0];
            end
        end
    end

`ifdef MUX_SEL_SEQUENCER_CONTINUOUS_EN
    logic [SEL_W-1:0] w_first_lat_ch;

    // Lowest enabled channel of the latched mask, used when a sweep wraps.
    always_comb begin
        w_first_lat_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i]) w_first_lat_ch = i[SEL_W-1:0];
        end
    end
`endif

    // Sequencer FSM plus the datapath registers it owns.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_ch    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop_in) begin
                // Abort: captured data/channel are left as they were.
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_in && (ch_mask_in != '0)) begin
                            r_mask  <= ch_mask_in;
                            r_dwell <= w_dwell_eff;
                            r_sel   <= w_first_in_ch;
                            r_cnt   <= w_dwell_eff - 1'b1;
                            r_state <= ST_SETTLE;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_data  <= mux_y_in;
                            r_ch    <= r_sel;
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_handshake) begin
                            r_valid <= 1'b0;
                            if (w_next_found) begin
                                r_sel   <= w_next_ch;
                                r_cnt   <= r_dwell - 1'b1;
                                r_state <= ST_SETTLE;
                            end else begin
                                r_done <= 1'b1;
`ifdef MUX_SEL_SEQUENCER_CONTINUOUS_EN
                                r_sel   <= w_first_lat_ch;
                                r_cnt   <= r_dwell - 1'b1;
                                r_state <= ST_SETTLE;
`else
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel_out          = r_sel;
    assign sample_valid_out = r_valid;
    assign sample_data_out  = r_data;
    assign sample_ch_out    = r_ch;
    assign busy_out         = r_busy;
    assign scan_done_out    = r_done;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer: directed sweeps push expected
// (channel, data) pairs; a negedge monitor pops on every accepted sample and
// also checks settle length and done-pulse behaviour.
module tb_mux_sel_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic       stop_in;
    logic [3:0] ch_mask_in;
    logic [7:0] dwell_in;
    logic       mux_y_in;
    logic [1:0] sel_out;
    logic       sample_valid_out;
    logic       sample_data_out;
    logic [1:0] sample_ch_out;
    logic       sample_ready_in;
    logic       busy_out;
    logic       scan_done_out;

    typedef struct packed {
        logic [1:0] ch;
        logic       d;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         pop_cnt = 0;
    int         settle_cnt = 0;
    int         exp_dwell = 1;
    logic       prev_valid = 1'b0;
    logic [3:0] pattern = 4'b0101;

    mux_sel_sequencer #(.NUM_CH(4), .SEL_W(2), .DWELL_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
        .ch_mask_in(ch_mask_in), .dwell_in(dwell_in), .mux_y_in(mux_y_in),
        .sel_out(sel_out), .sample_valid_out(sample_valid_out),
        .sample_data_out(sample_data_out), .sample_ch_out(sample_ch_out),
        .sample_ready_in(sample_ready_in), .busy_out(busy_out),
        .scan_done_out(scan_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Mux model: output mirrors the pattern bit picked by the select.
    always_comb mux_y_in = pattern[sel_out];

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Monitor: settle length, scoreboard pops, done pulses.
    always @(negedge clk_in) begin
        if (rst_in) begin
            settle_cnt = 0;
            prev_valid = 1'b0;
        end else begin
            if (sample_valid_out && !prev_valid) begin
                checks++;
                if (settle_cnt != exp_dwell) begin
                    errors++;
                    $display("FAIL settle_len: got %0d cycles, expected %0d", settle_cnt, exp_dwell);
                end
                settle_cnt = 0;
            end
            if (busy_out && !sample_valid_out) settle_cnt++;
            else if (!busy_out) settle_cnt = 0;
            if (sample_valid_out && sample_ready_in) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sample_unexpected: got ch=%0d d=%0b, expected none", sample_ch_out, sample_data_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    pop_cnt++;
                    if (sample_ch_out !== e.ch || sample_data_out !== e.d) begin
                        errors++;
                        $display("FAIL sample: got ch=%0d d=%0b, expected ch=%0d d=%0b",
                                 sample_ch_out, sample_data_out, e.ch, e.d);
                    end
                end
            end
            if (scan_done_out) begin
                done_cnt++;
                checks++;
`ifdef MUX_SEL_SEQUENCER_CONTINUOUS_EN
                if (busy_out !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_wrap: got %0b, expected 1", busy_out);
                end
`else
                if (busy_out !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %0b, expected 0", busy_out);
                end
`endif
            end
            prev_valid = sample_valid_out;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [7:0] d);
        ch_mask_in = m;
        dwell_in   = d;
        start_in   = 1'b1;
        tick();
        start_in   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done: got %0d pulses, expected %0d", done_cnt, target);
        end
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!sample_valid_out && n < limit) begin
            tick();
            n++;
        end
        if (!sample_valid_out) begin
            errors++;
            $display("FAIL wait_valid: got valid=0, expected 1");
        end
    endtask

    task automatic push(input logic [1:0] ch);
        exp_t e;
        e.ch = ch;
        e.d  = pattern[ch];
        q.push_back(e);
    endtask

    initial begin
        int base;
        rst_in = 1'b1; start_in = 1'b0; stop_in = 1'b0;
        ch_mask_in = '0; dwell_in = '0; sample_ready_in = 1'b0;
        tick(); tick();
        rst_in = 1'b0;
        tick();

        // Reset in the middle of a sweep.
        exp_dwell = 2;
        pulse_start(4'b1111, 8'd2);
        tick(); tick(); tick();
        rst_in = 1'b1;
        tick(); tick();
        chk("rst_sel", sel_out, 0);
        chk("rst_valid", sample_valid_out, 0);
        chk("rst_data", sample_data_out, 0);
        chk("rst_ch", sample_ch_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", scan_done_out, 0);
        rst_in = 1'b0;
        tick();

        // Single sweep, mask 1011, dwell 3, ready high.
        pattern = 4'b0101;
        exp_dwell = 3;
        sample_ready_in = 1'b1;
        push(2'd0); push(2'd1); push(2'd3);
        base = done_cnt;
        pulse_start(4'b1011, 8'd3);
        wait_done(base + 1, 60);
        tick(); tick();
        chk("sweep_done_count", done_cnt, base + 1);
        chk("sweep_queue_left", q.size(), 0);
        chk("sweep_idle_busy", busy_out, 0);

        // Backpressure, mask 0100, dwell 0 treated as 1.
        exp_dwell = 1;
        sample_ready_in = 1'b0;
        base = done_cnt;
        pulse_start(4'b0100, 8'd0);
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", sample_valid_out, 1);
            chk("bp_data", sample_data_out, 1);
            chk("bp_ch", sample_ch_out, 2);
            tick();
        end
        push(2'd2);
        sample_ready_in = 1'b1;
        wait_done(base + 1, 10);
        chk("bp_queue_left", q.size(), 0);

        // Start with empty mask is ignored.
        pulse_start(4'b0000, 8'd2);
        for (int k = 0; k < 3; k++) begin
            chk("empty_mask_busy", busy_out, 0);
            tick();
        end

        // Start during SETTLE and mid-sweep mask/dwell changes are ignored.
        exp_dwell = 3;
        base = done_cnt;
        push(2'd0); push(2'd1); push(2'd3);
        pulse_start(4'b1011, 8'd3);
        ch_mask_in = 4'b0001;
        dwell_in   = 8'd5;
        start_in   = 1'b1;
        tick();
        start_in   = 1'b0;
        wait_done(base + 1, 60);
        tick();
        chk("ign_done_count", done_cnt, base + 1);
        chk("ign_queue_left", q.size(), 0);

        // Abort in HOLD with channel 1 valid, then restart.
        pattern = 4'b0110;
        exp_dwell = 2;
        sample_ready_in = 1'b0;
        pulse_start(4'b0010, 8'd2);
        wait_valid(20);
        chk("abort_ch", sample_ch_out, 1);
        base = done_cnt;
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        chk("abort_valid", sample_valid_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_hold_ch", sample_ch_out, 1);
        chk("abort_done", scan_done_out, 0);
        tick();
        chk("abort_no_pulse", done_cnt, base);
        push(2'd1);
        sample_ready_in = 1'b1;
        pulse_start(4'b0010, 8'd2);
        wait_done(base + 1, 20);
        chk("abort_restart_queue", q.size(), 0);

`ifdef MUX_SEL_SEQUENCER_CONTINUOUS_EN
        // Continuous sweeps over 0,3 until stop.
        exp_dwell = 1;
        base = done_cnt;
        pop_cnt = 0;
        for (int k = 0; k < 8; k++) push((k % 2 == 0) ? 2'd0 : 2'd3);
        pulse_start(4'b1001, 8'd1);
        wait_done(base + 2, 40);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        chk("cont_stop_busy", busy_out, 0);
        checks++;
        if (pop_cnt < 4) begin
            errors++;
            $display("FAIL cont_pops: got %0d, expected at least 4", pop_cnt);
        end
        q.delete();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the team's 4:1 mux.
- Drives the mux's 2-bit select and samples the single-bit mux output once per enabled channel, in round-robin order.
- Each sample goes to a downstream consumer over a valid/ready handshake.
- A per-channel settle (dwell) interval lets the combinational mux path stabilise before capture.

Parameters:
- NUM_CH, 4, number of mux inputs scanned. Fixed at 4 for this mux.
- SEL_W, 2, select width. Must equal clog2(NUM_CH).
- DWELL_W, 8, width of the dwell counter and dwell_in.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  begin a sweep; sampled only in IDLE.
- stop_in  input  1  abort the sweep; takes priority over all other events except reset.
- ch_mask_in  input  NUM_CH  channel enable mask; bit i enables channel i.
- dwell_in  input  DWELL_W  settle cycles per channel; 0 is treated as 1.
- mux_y_in  input  1  mux output, sampled at capture.
- sel_out  output  SEL_W  mux select.
- sample_valid_out  output  1  sample available.
- sample_data_out  output  1  captured mux value.
- sample_ch_out  output  SEL_W  channel index of the current sample.
- sample_ready_in  input  1  consumer accepts the sample.
- busy_out  output  1  high in any state other than IDLE.
- scan_done_out  output  1  one-cycle pulse when the last enabled channel is accepted.

Behaviour:
- Reset (rst_in high at an edge): state IDLE; sel_out=0, sample_valid_out=0, sample_data_out=0, sample_ch_out=0, busy_out=0, scan_done_out=0, dwell counter=0, latched mask=0. Reset beats every other input.
- States are IDLE, SETTLE and HOLD.
- IDLE:
  - start_in=1 and ch_mask_in!=0 at edge E0: latch mask and dwell (D = max(dwell_in,1)); sel_out<=lowest enabled channel; counter<=D-1; go to SETTLE.
  - start_in with mask=0 is ignored; the block stays in IDLE.
  - start_in outside IDLE is ignored.
- SETTLE:
  - sel_out is held stable.
  - If counter!=0, decrement it.
  - If counter==0: sample_data_out<=mux_y_in; sample_ch_out<=sel_out; sample_valid_out<=1; go to HOLD.
  - Timing: sel_out is stable for exactly D cycles before the capture edge E0+D. sample_valid_out is high from the cycle after E0+D.
- HOLD:
  - sample_valid_out, sample_data_out and sample_ch_out stay constant until a handshake (valid & ready at an edge).
  - On handshake with another enabled channel above the current index: valid<=0; sel_out<=next higher enabled channel; counter<=D-1; go to SETTLE.
  - On handshake with no higher enabled channel: valid<=0; scan_done_out<=1 for exactly one cycle; go to IDLE. sel_out keeps its last value.
  - ready while valid=0 has no effect.
- stop_in at any edge outside reset: go to IDLE; valid<=0; scan_done_out<=0; sample_data_out and sample_ch_out hold their values; no done pulse.
- stop_in and start_in together in IDLE: the block stays in IDLE.
- Mask and dwell changes mid-sweep are ignored; the latched copies are used.
- Channel order is ascending index; disabled channels are skipped with no dead cycles.
- Back-to-back throughput with ready tied high: one sample per D+1 cycles per channel.
- busy_out is high in SETTLE and HOLD, low in IDLE. It is registered and tracks the state.

Optional Feature:
- Macro: MUX_SEL_SEQUENCER_CONTINUOUS_EN.
- Defined: on acceptance of the last enabled channel, scan_done_out still pulses, but the block wraps to the lowest enabled channel of the latched mask and re-enters SETTLE. Sweeps repeat until stop_in or reset. busy_out stays high across wraps.
- Not defined: the block returns to IDLE after one sweep, as described above.

Test Plan:
- Reset check: hold rst_in 2 cycles during a sweep -> all outputs 0 and state IDLE the cycle after the reset edge.
- Single sweep: mask=4'b1011, dwell=3, ready=1, mux_y_in mirrors pattern 4'b0101 indexed by sel_out -> samples (ch0,1), (ch1,0), (ch3,0); each capture occurs 3 cycles after its sel_out change; one scan_done_out pulse; busy_out falls on that same edge.
- Backpressure: mask=4'b0100, dwell=0, ready low for 5 cycles -> valid held 5 cycles with data/ch=2 constant; accepted on the first ready cycle; done pulse on that edge.
- Ignored inputs:
  - start with mask=0 -> no busy.
  - start during SETTLE -> sweep unchanged.
  - mask changed to 4'b0001 mid-sweep -> original latched channels still visited.
- Abort: stop_in asserted in HOLD with ch1 valid -> next cycle valid=0, busy=0, no scan_done_out pulse; new start works normally.
- CONTINUOUS_EN: mask=4'b1001, dwell=1, ready=1 -> channel sequence 0,3,0,3,... with a done pulse after each ch3 acceptance; stop_in ends the sequence.
